// File: rtl/filt_scan.sv
// filt_scan: multichannel debounce scheduler.
//
// One shared 4-state glitch filter is time-multiplexed across N raw inputs.
// A prescaler issues a scan tick every PRESCALE enabled cycles; each scan then
// services channels 0..N-1, one per clock. A channel's debounced level changes
// only after THRESH consecutive scans see the new level.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   en      in   global enable; low freezes prescaler, scan and filter state
//   i       in   [N]   raw asynchronous inputs
//   y       out  [N]   debounced levels (registered)
//   chg     out  one-cycle pulse when a channel commits a level change
//   chg_ch  out  [IW]  channel index of the most recent commit
//   chg_val out  new level of the most recent commit
//   busy    out  high while a scan is in progress
module filt_scan #(
  parameter int unsigned N        = 4,
  parameter int unsigned THRESH   = 10,
  parameter int unsigned PRESCALE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         i,
  output logic [N-1:0]         y,
  output logic                 chg,
  output logic [$clog2(N)-1:0] chg_ch,
  output logic                 chg_val,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(THRESH + 1);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned PW = $clog2(PRESCALE);

  localparam logic [PW-1:0] PcMax   = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IdxLast = IW'(N - 1);
  localparam logic [CW-1:0] CntLast = CW'(THRESH - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic [0:0] {StIdle, StScan} scan_e;

  // Z = committed low, E = committed high; *1 = change pending.
  typedef enum logic [1:0] {FltZ0, FltZ1, FltE0, FltE1} flt_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer, independent of en.
  // ---------------------------------------------------------------------------
  logic [N-1:0] is_meta_q, is_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_meta_q <= '0;
      is_q      <= '0;
    end else begin
      is_meta_q <= i;
      is_q      <= is_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and scan controller.
  // ---------------------------------------------------------------------------
  scan_e          state_q, state_d;
  logic [PW-1:0]  pc_q, pc_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           tick;
  logic           svc;

  assign tick = en && (pc_q == PcMax);
  // A channel is serviced only on enabled cycles, so a frozen scan resumes
  // at the same idx without skipping or repeating a channel.
  assign svc  = en && (state_q == StScan);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    if (en) begin
      pc_d = tick ? '0 : pc_q + PW'(1);
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            state_d = StScan;
          end
        end
        StScan: begin
          if (idx_q == IdxLast) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared filter engine: evaluates the serviced channel only.
  // ---------------------------------------------------------------------------
  flt_e [N-1:0]          st_q, st_d;
  logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]          y_q, y_d;

  logic                  s;
  flt_e                  cur_st, nxt_st;
  logic [CW-1:0]         cur_cnt, nxt_cnt;
  logic                  nxt_y;
  logic                  commit;

  always_comb begin
    s       = is_q[idx_q];
    cur_st  = st_q[idx_q];
    cur_cnt = cnt_q[idx_q];
    nxt_st  = cur_st;
    nxt_cnt = cur_cnt;
    nxt_y   = y_q[idx_q];
    commit  = 1'b0;

    case (cur_st)
      FltZ0: begin
        if (s) begin
          nxt_st  = FltZ1;
          nxt_cnt = CntOne;
        end else begin
          nxt_cnt = '0;
        end
      end
      FltZ1: begin
        if (!s) begin
          nxt_st  = FltZ0;
          nxt_cnt = '0;
        end else if (cur_cnt == CntLast) begin
          nxt_st  = FltE0;
          nxt_cnt = '0;
          nxt_y   = 1'b1;
          commit  = 1'b1;
        end else begin
          nxt_cnt = cur_cnt + CntOne;
        end
      end
      FltE0: begin
        if (!s) begin
          nxt_st  = FltE1;
          nxt_cnt = CntOne;
        end else begin
          nxt_cnt = '0;
        end
      end
      FltE1: begin
        if (s) begin
          nxt_st  = FltE0;
          nxt_cnt = '0;
        end else if (cur_cnt == CntLast) begin
          nxt_st  = FltZ0;
          nxt_cnt = '0;
          nxt_y   = 1'b0;
          commit  = 1'b1;
        end else begin
          nxt_cnt = cur_cnt + CntOne;
        end
      end
      default: begin
        nxt_st  = FltZ0;
        nxt_cnt = '0;
        nxt_y   = 1'b0;
      end
    endcase
  end

  // Write back only the serviced slot; every other channel holds.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    y_d   = y_q;
    if (svc) begin
      st_d[idx_q]  = nxt_st;
      cnt_d[idx_q] = nxt_cnt;
      y_d[idx_q]   = nxt_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= {N{FltZ0}};
      cnt_q <= '0;
      y_q   <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      y_q   <= y_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Commit reporting. chg is a single-cycle pulse (also cleared while en=0);
  // chg_ch/chg_val latch the most recent commit.
  // ---------------------------------------------------------------------------
  logic          chg_q, chg_d;
  logic [IW-1:0] chg_ch_q, chg_ch_d;
  logic          chg_val_q, chg_val_d;

  always_comb begin
    chg_d     = 1'b0;
    chg_ch_d  = chg_ch_q;
    chg_val_d = chg_val_q;
    if (svc && commit) begin
      chg_d     = 1'b1;
      chg_ch_d  = idx_q;
      chg_val_d = nxt_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_q     <= 1'b0;
      chg_ch_q  <= '0;
      chg_val_q <= 1'b0;
    end else begin
      chg_q     <= chg_d;
      chg_ch_q  <= chg_ch_d;
      chg_val_q <= chg_val_d;
    end
  end

  assign y       = y_q;
  assign chg     = chg_q;
  assign chg_ch  = chg_ch_q;
  assign chg_val = chg_val_q;
  assign busy    = (state_q == StScan);

endmodule

// File: tb/tb_filt_scan.sv
// Directed bench for filt_scan (N=4, THRESH=3, PRESCALE=8). Expected commits
// are queued when stimulus is applied and popped whenever chg pulses.
module tb_filt_scan;

  localparam int unsigned N = 4;
  localparam int unsigned T = 3;
  localparam int unsigned P = 8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] i;
  logic [3:0] y;
  logic       chg;
  logic [1:0] chg_ch;
  logic       chg_val;
  logic       busy;

  filt_scan #(
    .N        (N),
    .THRESH   (T),
    .PRESCALE (P)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .i       (i),
    .y       (y),
    .chg     (chg),
    .chg_ch  (chg_ch),
    .chg_val (chg_val),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ch;
    logic       val;
  } exp_t;

  exp_t exp_q[$];
  int   chg_cyc[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic val);
    exp_t e;
    e.ch  = ch;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // One clock; sample 1ns after the edge and score any chg pulse.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (chg === 1'b1) begin
      chg_cyc.push_back(cyc);
      chk("exp_avail", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("chg_ch", 32'(chg_ch), 32'(e.ch));
        chk("chg_val", 32'(chg_val), 32'(e.val));
      end
    end
  endtask

  task automatic wait_busy();
    int n = 0;
    while (busy !== 1'b1 && n < 4 * P) begin
      step();
      n++;
    end
    chk("busy_bound", (n < 4 * P) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic run_scan();
    int n = 0;
    while (busy !== 1'b1 && n < 4 * P) begin
      step();
      n++;
    end
    while (busy === 1'b1 && n < 4 * P) begin
      step();
      n++;
    end
    chk("scan_bound", (n < 4 * P) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic run_scans(input int k);
    for (int s = 0; s < k; s++) run_scan();
  endtask

  initial begin
    int n;
    int m;

    // ---- Reset, rise on channel 2 held from reset ----
    rst_n = 1'b0;
    en    = 1'b1;
    i     = 4'b0100;
    repeat (3) step();
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_chg", 32'(chg), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    n = 0;
    while (busy !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("first_tick", n, P);
    m = 0;
    while (busy === 1'b1 && m < 100) begin
      step();
      m++;
    end
    chk("busy_len", m, N);
    chk("rise_y_s1", 32'(y), 32'h0);
    run_scan();
    chk("rise_y_s2", 32'(y), 32'h0);
    push(2'd2, 1'b1);
    run_scan();
    chk("rise_y_s3", 32'(y), 32'b0100);

    // ---- Glitch on channel 0: 1,1,0 repeated never commits ----
    for (int r = 0; r < 3; r++) begin
      i = 4'b0101;
      run_scans(2);
      i = 4'b0100;
      run_scan();
      chk("glitch_y", 32'(y), 32'b0100);
    end

    // ---- Fall on channel 1, with a restart blip ----
    i = 4'b0110;
    run_scans(2);
    push(2'd1, 1'b1);
    run_scan();
    chk("ch1_high", 32'(y), 32'b0110);
    i = 4'b0100;
    run_scans(2);
    i = 4'b0110;
    run_scan();
    i = 4'b0100;
    run_scans(2);
    chk("blip_restart", 32'(y), 32'b0110);
    push(2'd1, 1'b0);
    run_scan();
    chk("fall_y", 32'(y), 32'b0100);

    // ---- Freeze at idx=2 in a scan where channels 2 and 3 commit ----
    i = 4'b1000;
    run_scans(2);
    push(2'd2, 1'b0);
    push(2'd3, 1'b1);
    wait_busy();
    step();
    step();
    en = 1'b0;
    chg_cyc.delete();
    n = 0;
    repeat (20) begin
      step();
      if (busy === 1'b1) n++;
    end
    chk("frz_busy", n, 20);
    chk("frz_chg", chg_cyc.size(), 0);
    chk("frz_y", 32'(y), 32'b0100);
    en = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("resume_len", n, 2);
    chk("resume_pulses", chg_cyc.size(), 2);
    if (chg_cyc.size() == 2) chk("resume_gap", chg_cyc[1] - chg_cyc[0], 1);
    n = 0;
    while (busy !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("pc_hold", n, P - N);
    run_scan();
    chk("frz_after_y", 32'(y), 32'b1000);

    // ---- Simultaneous commits on all channels ----
    i = 4'b0000;
    run_scans(2);
    push(2'd3, 1'b0);
    run_scan();
    chk("all_low_y", 32'(y), 32'h0);
    i = 4'b1111;
    run_scans(2);
    for (int k = 0; k < 4; k++) push(2'(k), 1'b1);
    chg_cyc.delete();
    run_scan();
    chk("all_high_y", 32'(y), 32'b1111);
    chk("sim_pulses", chg_cyc.size(), 4);
    for (int k = 1; k < chg_cyc.size(); k++) chk("sim_gap", chg_cyc[k] - chg_cyc[k-1], 1);

    // ---- Reset mid-scan with y=1010 ----
    i = 4'b1010;
    run_scans(2);
    push(2'd0, 1'b0);
    push(2'd2, 1'b0);
    run_scan();
    chk("pre_rst_y", 32'(y), 32'b1010);
    i = 4'b0000;
    wait_busy();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_chg", 32'(chg), 32'h0);
    chk("arst_chg_ch", 32'(chg_ch), 32'h0);
    chk("arst_chg_val", 32'(chg_val), 32'h0);
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("rst_tick", n, P);
    run_scan();
    chk("rst_after_y", 32'(y), 32'h0);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
